// File: rtl/clk_mon_pkg.sv
// Shared definitions for the clock_monitor slice.
//   STATE_W : width of the monitor FSM state register
//   state_t : IDLE (waiting for a first edge), MEASURE (counting matches),
//             LOCKED (LOCK_COUNT consecutive in-tolerance half-periods seen)
package clk_mon_pkg;

  localparam int STATE_W = 2;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE    = 2'd0,
    ST_MEASURE = 2'd1,
    ST_LOCKED  = 2'd2
  } state_t;

endpackage

// File: rtl/edge_sync.sv
// edge_sync: brings an asynchronous level into the clk domain and reports its edges.
// Reusable for buttons, slow clocks and other async inputs.
// Ports:
//   clk       in  1  sampling clock, all state on posedge
//   rst       in  1  asynchronous active-high reset
//   async_in  in  1  asynchronous input level
//   rise_tick out 1  registered one-cycle pulse per synchronised rising edge
//   fall_tick out 1  registered one-cycle pulse per synchronised falling edge
//   edge_det  out 1  combinational strobe, high in the cycle an edge is seen on
//                    the synchronised level; aligned so that logic clocked on
//                    the same edge updates together with the ticks
module edge_sync (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise_tick,
  output logic fall_tick,
  output logic edge_det
);

  // s0/s1 form the two-flop synchroniser, s2 holds the previous synchronised level
  logic s0;
  logic s1;
  logic s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s0        <= 1'b0;
      s1        <= 1'b0;
      s2        <= 1'b0;
      rise_tick <= 1'b0;
      fall_tick <= 1'b0;
    end else begin
      s0        <= async_in;
      s1        <= s0;
      s2        <= s1;
      rise_tick <= s1 & ~s2;
      fall_tick <= ~s1 & s2;
    end
  end

  assign edge_det = s1 ^ s2;

endmodule

// File: rtl/clock_monitor.sv
// clock_monitor: consumer end of a clock divider. Turns a slow square wave into
// fast-domain rise/fall ticks, measures every half-period in clk cycles and
// reports lock and loss-of-signal.
// Ports:
//   clk          in  1     single clock, all state on posedge
//   rst          in  1     asynchronous active-high reset
//   slow_in      in  1     slow square wave, asynchronous to clk
//   rise_tick    out 1     one-cycle pulse per synchronised rising edge
//   fall_tick    out 1     one-cycle pulse per synchronised falling edge
//   half_period  out BITS  last published half-period in clk cycles
//   period_valid out 1     one-cycle pulse when half_period updates
//   locked       out 1     LOCK_COUNT consecutive matches, no mismatch since
//   lost         out 1     sticky loss-of-signal, cleared by the next edge
module clock_monitor
  import clk_mon_pkg::*;
#(
  parameter int BITS          = 32,
  parameter int EXPECTED_HALF = 250000,
  parameter int TOL           = 16,
  parameter int LOCK_COUNT    = 4,
  parameter int TIMEOUT       = 500000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            slow_in,
  output logic            rise_tick,
  output logic            fall_tick,
  output logic [BITS-1:0] half_period,
  output logic            period_valid,
  output logic            locked,
  output logic            lost
);

  localparam int              MW        = $clog2(LOCK_COUNT + 1);
  localparam logic [BITS:0]   EXP_W     = (BITS+1)'(EXPECTED_HALF);
  localparam logic [BITS:0]   TOL_W     = (BITS+1)'(TOL);
  localparam logic [BITS-1:0] TIMEOUT_W = BITS'(TIMEOUT);
  localparam logic [MW-1:0]   LOCK_W    = MW'(LOCK_COUNT);
  localparam logic [MW-1:0]   LOCK_LAST = MW'(LOCK_COUNT - 1);

  logic            edge_det;
  logic [BITS-1:0] hcnt;
  logic [BITS:0]   meas_ext;
  logic [BITS:0]   diff;
  logic            is_match;
  logic            timeout_hit;
  logic [MW-1:0]   match_cnt;
  state_t          state;

  edge_sync u_sync (
    .clk       (clk),
    .rst       (rst),
    .async_in  (slow_in),
    .rise_tick (rise_tick),
    .fall_tick (fall_tick),
    .edge_det  (edge_det)
  );

  // Half-period counter: reloads to 1 on an edge so that the value seen on the
  // following edge equals the number of clk cycles between the two edges.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hcnt <= '0;
    end else if (edge_det) begin
      hcnt <= BITS'(1);
    end else if (hcnt != '1) begin
      hcnt <= hcnt + 1'b1;
    end
  end

  // Tolerance compare done one bit wider so the difference never wraps.
  always_comb begin
    meas_ext = {1'b0, hcnt};
    diff     = '0;
    if (meas_ext >= EXP_W) begin
      diff = meas_ext - EXP_W;
    end else begin
      diff = EXP_W - meas_ext;
    end
    is_match    = (diff <= TOL_W);
    timeout_hit = (hcnt == TIMEOUT_W);
  end

  // Monitor FSM with registered outputs. An edge always takes priority over a
  // timeout landing on the same cycle, so that half-period gets published.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= ST_IDLE;
      match_cnt    <= '0;
      half_period  <= '0;
      period_valid <= 1'b0;
      locked       <= 1'b0;
      lost         <= 1'b0;
    end else begin
      period_valid <= 1'b0;
      if (edge_det) begin
        lost <= 1'b0;
      end

      case (state)
        ST_IDLE: begin
          // First edge only starts timing; the count before it is meaningless.
          if (edge_det) begin
            state     <= ST_MEASURE;
            match_cnt <= '0;
          end
        end

        ST_MEASURE: begin
          if (edge_det) begin
            half_period  <= hcnt;
            period_valid <= 1'b1;
            if (is_match) begin
              if (match_cnt == LOCK_LAST) begin
                state     <= ST_LOCKED;
                locked    <= 1'b1;
                match_cnt <= LOCK_W;
              end else begin
                match_cnt <= match_cnt + 1'b1;
              end
            end else begin
              match_cnt <= '0;
            end
          end else if (timeout_hit) begin
            state     <= ST_IDLE;
            lost      <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        end

        ST_LOCKED: begin
          if (edge_det) begin
            half_period  <= hcnt;
            period_valid <= 1'b1;
            if (!is_match) begin
              state     <= ST_MEASURE;
              match_cnt <= '0;
              locked    <= 1'b0;
            end
          end else if (timeout_hit) begin
            state     <= ST_IDLE;
            lost      <= 1'b1;
            locked    <= 1'b0;
            match_cnt <= '0;
          end
        end

        default: begin
          state     <= ST_IDLE;
          match_cnt <= '0;
          locked    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_monitor.sv
// Directed bench for clock_monitor with EXPECTED_HALF=10, TOL=1, LOCK_COUNT=4,
// TIMEOUT=25, BITS=8. slow_in is toggled a fixed number of clk cycles after the
// previous toggle; outputs are sampled 1ns after posedge.
module tb_clock_monitor;

  logic       clk;
  logic       rst;
  logic       slow_in;
  logic       rise_tick;
  logic       fall_tick;
  logic [7:0] half_period;
  logic       period_valid;
  logic       locked;
  logic       lost;

  int checks   = 0;
  int failures = 0;

  clock_monitor #(
    .BITS          (8),
    .EXPECTED_HALF (10),
    .TOL           (1),
    .LOCK_COUNT    (4),
    .TIMEOUT       (25)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .slow_in      (slow_in),
    .rise_tick    (rise_tick),
    .fall_tick    (fall_tick),
    .half_period  (half_period),
    .period_valid (period_valid),
    .locked       (locked),
    .lost         (lost)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Toggle slow_in h clk cycles after the previous toggle, check the edge
  // response 3 cycles later, then check the pulses drop one cycle after that.
  task automatic gap(input int h, input logic exp_pv, input logic [7:0] exp_hp,
                     input logic exp_lock, input string tag);
    clk_n(h - 4);
    slow_in = ~slow_in;
    clk_n(3);
    chk1({tag, ".rise"},   rise_tick,    slow_in);
    chk1({tag, ".fall"},   fall_tick,    ~slow_in);
    chk1({tag, ".pv"},     period_valid, exp_pv);
    chk8({tag, ".hp"},     half_period,  exp_hp);
    chk1({tag, ".locked"}, locked,       exp_lock);
    chk1({tag, ".lost"},   lost,         1'b0);
    clk_n(1);
    chk1({tag, ".rise_end"}, rise_tick,    1'b0);
    chk1({tag, ".fall_end"}, fall_tick,    1'b0);
    chk1({tag, ".pv_end"},   period_valid, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    slow_in = 1'b0;
    clk_n(3);
    chk1("rst.rise",   rise_tick,    1'b0);
    chk1("rst.fall",   fall_tick,    1'b0);
    chk1("rst.pv",     period_valid, 1'b0);
    chk8("rst.hp",     half_period,  8'd0);
    chk1("rst.locked", locked,       1'b0);
    chk1("rst.lost",   lost,         1'b0);
    rst = 1'b0;

    // 1: nominal 10-cycle half-periods, first edge unpublished, lock on 5th edge
    gap(10, 1'b0, 8'd0,  1'b0, "t1e1");
    gap(10, 1'b1, 8'd10, 1'b0, "t1e2");
    gap(10, 1'b1, 8'd10, 1'b0, "t1e3");
    gap(10, 1'b1, 8'd10, 1'b0, "t1e4");
    gap(10, 1'b1, 8'd10, 1'b1, "t1e5");

    // 3: one out-of-tolerance half-period drops lock, four good ones relock
    gap(14, 1'b1, 8'd14, 1'b0, "t3bad");
    gap(10, 1'b1, 8'd10, 1'b0, "t3m1");
    gap(10, 1'b1, 8'd10, 1'b0, "t3m2");
    gap(10, 1'b1, 8'd10, 1'b0, "t3m3");
    gap(10, 1'b1, 8'd10, 1'b1, "t3relock");

    // 2: 12-cycle half-periods are published but never match (|12-10| > 1)
    gap(12, 1'b1, 8'd12, 1'b0, "t2a");
    gap(12, 1'b1, 8'd12, 1'b0, "t2b");
    gap(12, 1'b1, 8'd12, 1'b0, "t2c");
    gap(10, 1'b1, 8'd10, 1'b0, "t2m1");
    gap(10, 1'b1, 8'd10, 1'b0, "t2m2");
    gap(10, 1'b1, 8'd10, 1'b0, "t2m3");
    gap(10, 1'b1, 8'd10, 1'b1, "t2relock");

    // 4: hold slow_in; hcnt reaches 25 on the 24th cycle after the edge update
    clk_n(23);
    chk1("t4.lost_before",   lost,   1'b0);
    chk1("t4.locked_before", locked, 1'b1);
    clk_n(1);
    chk1("t4.lost",   lost,   1'b1);
    chk1("t4.locked", locked, 1'b0);
    chk8("t4.hp",     half_period, 8'd10);
    clk_n(5);
    chk1("t4.lost_held", lost, 1'b1);
    gap(10, 1'b0, 8'd10, 1'b0, "t4resume1");
    gap(10, 1'b1, 8'd10, 1'b0, "t4resume2");

    // 5: half-period exactly TIMEOUT -> edge wins and 25 is published
    gap(25, 1'b1, 8'd25, 1'b0, "t5edge25");

    // 26-cycle half-period: timeout fires one cycle before the edge arrives
    clk_n(22);
    slow_in = ~slow_in;
    clk_n(1);
    chk1("t5b.lost_before", lost, 1'b0);
    clk_n(1);
    chk1("t5b.lost", lost, 1'b1);
    clk_n(1);
    chk1("t5b.lost_clr", lost,         1'b0);
    chk1("t5b.pv",       period_valid, 1'b0);
    chk8("t5b.hp",       half_period,  8'd25);
    chk1("t5b.tick",     rise_tick | fall_tick, 1'b1);
    clk_n(1);

    // 6: async reset mid-MEASURE with slow_in high
    clk_n(2);
    rst     = 1'b1;
    slow_in = 1'b1;
    #1;
    chk8("t6.hp_rst",  half_period,  8'd0);
    chk1("t6.pv_rst",  period_valid, 1'b0);
    chk1("t6.lk_rst",  locked,       1'b0);
    chk1("t6.lst_rst", lost,         1'b0);
    chk1("t6.rt_rst",  rise_tick,    1'b0);
    clk_n(3);
    rst = 1'b0;
    clk_n(2);
    chk1("t6.rise_early", rise_tick, 1'b0);
    clk_n(1);
    chk1("t6.rise",   rise_tick,    1'b1);
    chk1("t6.pv",     period_valid, 1'b0);
    chk8("t6.hp",     half_period,  8'd0);
    clk_n(1);
    chk1("t6.rise_end", rise_tick, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
